// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry input FIFO in front of the serialiser.
module uart_tx_frame #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BIT_RATE   = 9600,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          uart_tx_valid,
   output logic                          uart_tx_ready,
   input  logic [DATA_BITS-1:0]          uart_tx_data,
   output logic                          uart_txd,
   output logic                          uart_tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   uart_tx_level
);

   localparam int unsigned CyclesPerBit = CLK_HZ / BIT_RATE;
   localparam int unsigned CntW         = (CyclesPerBit < 2) ? 1 : $clog2(CyclesPerBit);
   localparam int unsigned LvlW         = $clog2(FIFO_DEPTH) + 1;

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (CyclesPerBit < 2) begin : g_bad_divisor
      $error("uart_tx_frame: CLK_HZ/BIT_RATE must be >= 2");
   end

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cyc_q, cyc_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  txd_q, txd_d;

   logic                  bit_end;
   logic                  last_stop;
   logic                  load;
   logic [DATA_BITS-1:0]  load_data;

   assign bit_end   = (cyc_q == CntW'(CyclesPerBit - 1));
   assign last_stop = (state_q == StStop) && bit_end && (bit_q == 4'(STOP_BITS - 1));

`ifdef UART_TX_FIFO_EN
   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
      $error("uart_tx_frame: FIFO_DEPTH must be a power of 2 >= 2");
   end

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AddrW-1:0]     wr_q, rd_q;
   logic [LvlW-1:0]      level_q;
   logic                 push;
   logic                 can_load;

   assign uart_tx_ready = !reset && (level_q != LvlW'(FIFO_DEPTH));
   assign push          = uart_tx_valid && uart_tx_ready;
   // Pop on the last stop cycle so the next frame starts with no idle gap.
   assign can_load      = (state_q == StIdle) || last_stop;
   assign load          = can_load && (level_q != '0);
   assign load_data     = mem_q[rd_q];
   assign uart_tx_level = level_q;
   assign uart_tx_busy  = (state_q != StIdle) || (level_q != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= uart_tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (load) rd_q <= rd_q + 1'b1;
         level_q <= level_q + LvlW'(push) - LvlW'(load);
      end
   end
`else
   assign uart_tx_ready = (state_q == StIdle) && !reset;
   assign load          = uart_tx_valid && uart_tx_ready;
   assign load_data     = uart_tx_data;
   assign uart_tx_level = '0;
   assign uart_tx_busy  = (state_q != StIdle);
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      if (state_q != StIdle) begin
         cyc_d = bit_end ? '0 : cyc_q + 1'b1;
      end
      unique case (state_q)
         StIdle: ;
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = '0;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? StParity : StStop;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
               bit_d   = '0;
            end
         end
         StStop: begin
            if (last_stop) begin
               state_d = StIdle;
               bit_d   = '0;
            end else if (bit_end) begin
               bit_d = bit_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         state_d = StStart;
         cyc_d   = '0;
         bit_d   = '0;
         shift_d = load_data;
         par_d   = (PARITY == 1) ? ~^load_data : ^load_data;
      end
   end

   // Line level follows the current state, so the pin lags the state register by one clock.
   always_comb begin
      txd_d = 1'b1;
      unique case (state_q)
         StIdle:   txd_d = 1'b1;
         StStart:  txd_d = 1'b0;
         StData:   txd_d = shift_q[0];
         StParity: txd_d = par_q;
         StStop:   txd_d = 1'b1;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cyc_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
      end
   end

   assign uart_txd = txd_q;

endmodule
